riscv_decode_queue: RTL and testbench

Parametrised multi-lane decode stage with a decoded-instruction queue, placed between fetch and issue in the dual-issue core. Each cycle it accepts up to LANES fetched instructions, classifies each by functional unit (exec, LSU, branch, mul, div, CSR/system) and destination-register use, and stores the results in a DEPTH-entry circular queue. Issue pulls up to LANES in-order entries per cycle. The block adds buffering, flush, lane compaction and x0 write suppression to the single-instruction combinational decoder.

---
 rtl/riscv_decode_queue.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_riscv_decode_queue.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : riscv_decode_queue
// Purpose  : Multi-lane decode stage with a decoded-instruction circular
//            queue between fetch and issue. Each accepted fetch bundle is
//            classified per lane (functional unit, rd usage) and the masked
//            lanes are compacted into consecutive tail slots. Issue reads up to
//            LANES in-order entries starting at the head.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i           clock, all state on rising edge
//   rst_ni          asynchronous active-low reset
//   flush_i         drop every queued entry (and any same-cycle enqueue)
//   en_muldiv_i     runtime M-extension enable, sampled at enqueue
//   fetch_valid_i   fetch bundle present
//   fetch_mask_i    per-lane valid
//   fetch_instr_i   lane k instruction in [32k+31:32k]
//   fetch_pc_i      PC of lane 0 (lane k is +4k)
//   fetch_fault_i   fetch fault for every masked lane
//   fetch_accept_o  bundle taken when fetch_valid_i is high
//   issue_valid_o   thermometer, slot k valid when count_o > k
//   issue_instr_o   head+k instruction
//   issue_pc_o      head+k PC
//   issue_class_o   {invalid,csr,div,mul,branch,lsu,exec,writes_rd} per slot
//   issue_take_i    number of head entries consumed this edge
//   count_o         occupied entries
// ============================================================================
module riscv_decode_queue #(
    parameter int LANES          = 2,
    parameter int DEPTH          = 8,
    parameter int SUPPORT_MULDIV = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         en_muldiv_i,
    input  logic                         fetch_valid_i,
    input  logic [LANES-1:0]             fetch_mask_i,
    input  logic [32*LANES-1:0]          fetch_instr_i,
    input  logic [31:0]                  fetch_pc_i,
    input  logic                         fetch_fault_i,
    output logic                         fetch_accept_o,
    output logic [LANES-1:0]             issue_valid_o,
    output logic [32*LANES-1:0]          issue_instr_o,
    output logic [32*LANES-1:0]          issue_pc_o,
    output logic [8*LANES-1:0]           issue_class_o,
    input  logic [$clog2(LANES+1)-1:0]   issue_take_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);

    // Major opcodes
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [6:0] F7_SFENCE = 7'b0001001;

    localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSN_MRET   = 32'h3020_0073;
    localparam logic [31:0] INSN_WFI    = 32'h1050_0073;

    // A faulted lane is routed to the CSR/system unit only.
    localparam logic [7:0] FAULT_CLS = 8'h40;

    // ------------------------------------------------------------------------
    // Single-instruction classifier. Returns
    // {invalid, csr, div, mul, branch, lsu, exec, writes_rd}.
    // ------------------------------------------------------------------------
    function automatic logic [7:0] decode_class(input logic [31:0] instr,
                                                input logic        md_en);
        logic [6:0] opcode;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       is_exec;
        logic       is_lsu;
        logic       is_br;
        logic       is_mul;
        logic       is_div;
        logic       is_sys;
        logic       uses_rd;
        logic       is_inv;

        opcode  = instr[6:0];
        f3      = instr[14:12];
        f7      = instr[31:25];
        is_exec = 1'b0;
        is_lsu  = 1'b0;
        is_br   = 1'b0;
        is_mul  = 1'b0;
        is_div  = 1'b0;
        is_sys  = 1'b0;
        uses_rd = 1'b0;

        case (opcode)
            OPC_OP_IMM: begin
                // Only the shift-immediate forms constrain funct7.
                if (f3 == 3'b001)
                    is_exec = (f7 == F7_BASE);
                else if (f3 == 3'b101)
                    is_exec = (f7 == F7_BASE) || (f7 == F7_ALT);
                else
                    is_exec = 1'b1;
                uses_rd = is_exec;
            end
            OPC_LUI, OPC_AUIPC: begin
                is_exec = 1'b1;
                uses_rd = 1'b1;
            end
            OPC_OP: begin
                if (f7 == F7_BASE)
                    is_exec = 1'b1;
                else if (f7 == F7_ALT)
                    is_exec = (f3 == 3'b000) || (f3 == 3'b101);
                else if ((f7 == F7_MULDIV) && md_en) begin
                    is_mul = ~f3[2];
                    is_div = f3[2];
                end
                uses_rd = is_exec | is_mul | is_div;
            end
            OPC_LOAD: begin
                is_lsu  = (f3 != 3'b011) && (f3 != 3'b111);
                uses_rd = is_lsu;
            end
            OPC_STORE: begin
                is_lsu = (f3[2] == 1'b0) && (f3 != 3'b011);
            end
            OPC_JAL: begin
                is_br   = 1'b1;
                uses_rd = 1'b1;
            end
            OPC_JALR: begin
                is_br   = (f3 == 3'b000);
                uses_rd = is_br;
            end
            OPC_BRANCH: begin
                is_br = (f3 != 3'b010) && (f3 != 3'b011);
            end
            OPC_MISC_MEM: begin
                // FENCE and FENCE.I
                is_sys = (f3 == 3'b000) || (f3 == 3'b001);
            end
            OPC_SYSTEM: begin
                if (f3 == 3'b000) begin
                    // SFENCE.VMA: any rs1/rs2, rd and funct3 must be zero.
                    is_sys = (instr == INSN_ECALL)  || (instr == INSN_EBREAK) ||
                             (instr == INSN_MRET)   || (instr == INSN_WFI)    ||
                             ((f7 == F7_SFENCE) && (instr[14:7] == 8'h00));
                end else if (f3 != 3'b100) begin
                    is_sys  = 1'b1;
                    uses_rd = 1'b1;
                end
            end
            default: ;
        endcase

        is_inv = ~(is_exec | is_lsu | is_br | is_mul | is_div | is_sys);

        // x0 destinations never request a writeback slot.
        return {is_inv, is_sys | is_inv, is_div, is_mul, is_br, is_lsu, is_exec,
                uses_rd & (instr[11:7] != 5'd0) & ~is_inv};
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] instr_q [DEPTH];
    logic [31:0] pc_q    [DEPTH];
    logic [7:0]  cls_q   [DEPTH];

    // ------------------------------------------------------------------------
    // Per-lane compaction and classification
    // ------------------------------------------------------------------------
    logic [LANES-1:0][PTR_W-1:0] lane_idx;
    logic [LANES-1:0][7:0]       lane_cls;
    logic [CNT_W-1:0]            pop_cnt;
    logic                        md_en;

    assign md_en = (SUPPORT_MULDIV != 0) && en_muldiv_i;

    always_comb begin
        pop_cnt  = '0;
        lane_idx = '0;
        lane_cls = '0;
        for (int k = 0; k < LANES; k++) begin
            // Lane k lands after all lower-numbered masked lanes.
            lane_idx[k] = tail_q + pop_cnt[PTR_W-1:0];
            lane_cls[k] = fetch_fault_i ? FAULT_CLS
                                        : decode_class(fetch_instr_i[32*k +: 32], md_en);
            if (fetch_mask_i[k])
                pop_cnt = pop_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Pointer / occupancy control
    // ------------------------------------------------------------------------
    logic             enq;
    logic [CNT_W-1:0] take_req;
    logic [CNT_W-1:0] take_eff;
    logic [CNT_W-1:0] enq_cnt;

    // Only registered occupancy feeds accept, so fetch never sees issue timing.
    assign fetch_accept_o = (DEPTH_C - count_q) >= LANES_C;
    assign enq            = fetch_valid_i && fetch_accept_o && !flush_i;
    assign take_req       = CNT_W'(issue_take_i);
    assign take_eff       = (take_req > count_q) ? count_q : take_req;
    assign enq_cnt        = enq ? pop_cnt : '0;

    always_comb begin
        head_d  = head_q + take_eff[PTR_W-1:0];
        tail_d  = tail_q + enq_cnt[PTR_W-1:0];
        count_d = count_q - take_eff + enq_cnt;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < DEPTH; e++) begin
                instr_q[e] <= '0;
                pc_q[e]    <= '0;
                cls_q[e]   <= '0;
            end
        end else if (enq) begin
            for (int k = 0; k < LANES; k++) begin
                if (fetch_mask_i[k]) begin
                    instr_q[lane_idx[k]] <= fetch_instr_i[32*k +: 32];
                    pc_q[lane_idx[k]]    <= fetch_pc_i + 32'(4*k);
                    cls_q[lane_idx[k]]   <= lane_cls[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Issue window: slots beyond the occupancy read as zero.
    // ------------------------------------------------------------------------
    logic [PTR_W-1:0] rd_idx;

    always_comb begin
        issue_valid_o = '0;
        issue_instr_o = '0;
        issue_pc_o    = '0;
        issue_class_o = '0;
        rd_idx        = '0;
        for (int k = 0; k < LANES; k++) begin
            rd_idx = head_q + PTR_W'(k);
            if (CNT_W'(k) < count_q) begin
                issue_valid_o[k]         = 1'b1;
                issue_instr_o[32*k +: 32] = instr_q[rd_idx];
                issue_pc_o[32*k +: 32]    = pc_q[rd_idx];
                issue_class_o[8*k +: 8]   = cls_q[rd_idx];
            end
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_decode_queue.sv
`default_nettype none
module tb_riscv_decode_queue;

    localparam int LANES  = 2;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int TAKE_W = $clog2(LANES+1);

    logic                    clk_i = 1'b0;
    logic                    rst_ni = 1'b0;
    logic                    flush_i = 1'b0;
    logic                    en_muldiv_i = 1'b1;
    logic                    fetch_valid_i = 1'b0;
    logic [LANES-1:0]        fetch_mask_i = '0;
    logic [32*LANES-1:0]     fetch_instr_i = '0;
    logic [31:0]             fetch_pc_i = '0;
    logic                    fetch_fault_i = 1'b0;
    logic                    fetch_accept_o;
    logic [LANES-1:0]        issue_valid_o;
    logic [32*LANES-1:0]     issue_instr_o;
    logic [32*LANES-1:0]     issue_pc_o;
    logic [8*LANES-1:0]      issue_class_o;
    logic [TAKE_W-1:0]       issue_take_i = '0;
    logic [CNT_W-1:0]        count_o;

    riscv_decode_queue #(
        .LANES(LANES), .DEPTH(DEPTH), .SUPPORT_MULDIV(1)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .en_muldiv_i(en_muldiv_i),
        .fetch_valid_i(fetch_valid_i), .fetch_mask_i(fetch_mask_i),
        .fetch_instr_i(fetch_instr_i), .fetch_pc_i(fetch_pc_i),
        .fetch_fault_i(fetch_fault_i), .fetch_accept_o(fetch_accept_o),
        .issue_valid_o(issue_valid_o), .issue_instr_o(issue_instr_o),
        .issue_pc_o(issue_pc_o), .issue_class_o(issue_class_o),
        .issue_take_i(issue_take_i), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [7:0]  cls;
    } entry_t;

    entry_t mq[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference classifier, written directly from the ISA classification rules.
    function automatic logic [7:0] ref_classify(input logic [31:0] ins, input logic md);
        int  op, f3, f7, rd;
        bit  ex, ls, br, mu, dv, cs, wr, inv;
        op = int'(ins[6:0]); f3 = int'(ins[14:12]); f7 = int'(ins[31:25]); rd = int'(ins[11:7]);
        ex = 0; ls = 0; br = 0; mu = 0; dv = 0; cs = 0; wr = 0;
        if (op == 'h13) begin
            ex = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 'h20) : 1'b1;
            wr = ex;
        end else if (op == 'h37 || op == 'h17) begin
            ex = 1; wr = 1;
        end else if (op == 'h33) begin
            if (f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5))) begin ex = 1; wr = 1; end
            else if (f7 == 1 && md) begin mu = (f3 < 4); dv = (f3 >= 4); wr = 1; end
        end else if (op == 'h03) begin
            ls = (f3 inside {0, 1, 2, 4, 5, 6}); wr = ls;
        end else if (op == 'h23) begin
            ls = (f3 <= 2);
        end else if (op == 'h6F) begin
            br = 1; wr = 1;
        end else if (op == 'h67) begin
            br = (f3 == 0); wr = br;
        end else if (op == 'h63) begin
            br = !(f3 == 2 || f3 == 3);
        end else if (op == 'h0F) begin
            cs = (f3 <= 1);
        end else if (op == 'h73) begin
            if (ins == 32'h73 || ins == 32'h100073 || ins == 32'h30200073 ||
                ins == 32'h10500073 || (f7 == 9 && ins[14:7] == 8'h00))
                cs = 1;
            else if (f3 != 0 && f3 != 4) begin cs = 1; wr = 1; end
        end
        inv = !(ex || ls || br || mu || dv || cs);
        if (inv) begin cs = 1; wr = 0; end
        if (rd == 0) wr = 0;
        return {inv, cs, dv, mu, br, ls, ex, wr};
    endfunction

    task automatic check_outputs(input string ph);
        int n;
        entry_t e;
        n = mq.size();
        check_eq({ph, ":count"}, 64'(count_o), 64'(n));
        check_eq({ph, ":accept"}, 64'(fetch_accept_o), 64'((DEPTH - n) >= LANES));
        for (int k = 0; k < LANES; k++) begin
            e = '0;
            if (k < n) e = mq[k];
            check_eq($sformatf("%s:valid%0d", ph, k), 64'(issue_valid_o[k]), 64'(k < n));
            check_eq($sformatf("%s:instr%0d", ph, k), 64'(issue_instr_o[32*k +: 32]), 64'(e.instr));
            check_eq($sformatf("%s:pc%0d", ph, k), 64'(issue_pc_o[32*k +: 32]), 64'(e.pc));
            check_eq($sformatf("%s:class%0d", ph, k), 64'(issue_class_o[8*k +: 8]), 64'(e.cls));
        end
    endtask

    // Applies this cycle's inputs to the queue model as the DUT edge does.
    task automatic model_step();
        bit     acc;
        entry_t e;
        acc = (DEPTH - mq.size()) >= LANES;
        if (flush_i) begin
            mq.delete();
        end else begin
            for (int i = 0; i < int'(issue_take_i) && mq.size() > 0; i++) mq.delete(0);
            if (fetch_valid_i && acc) begin
                for (int k = 0; k < LANES; k++) begin
                    if (fetch_mask_i[k]) begin
                        e.instr = fetch_instr_i[32*k +: 32];
                        e.pc    = fetch_pc_i + 32'(4*k);
                        e.cls   = fetch_fault_i ? 8'h40 : ref_classify(e.instr, en_muldiv_i);
                        mq.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] i0,
                         input logic [31:0] i1, input logic [31:0] pc, input logic flt,
                         input logic en, input int take, input logic fl);
        fetch_valid_i = v;
        fetch_mask_i  = m;
        fetch_instr_i = {i1, i0};
        fetch_pc_i    = pc;
        fetch_fault_i = flt;
        en_muldiv_i   = en;
        issue_take_i  = TAKE_W'(take);
        flush_i       = fl;
    endtask

    task automatic cycle(input string ph);
        @(negedge clk_i);
        check_outputs(ph);
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [0:10];
        logic [6:0]  f7s [0:2];
        logic [31:0] sp  [0:4];
        ops = '{7'h13, 7'h37, 7'h17, 7'h33, 7'h03, 7'h23, 7'h6F, 7'h67, 7'h63, 7'h0F, 7'h73};
        f7s = '{7'h00, 7'h20, 7'h01};
        sp  = '{32'h00000073, 32'h00100073, 32'h30200073, 32'h10500073, 32'h12A00073};
        r = $urandom;
        case ($urandom_range(0, 9))
            0:       r = sp[$urandom_range(0, 4)];
            1:       ;
            default: begin
                r[6:0] = ops[$urandom_range(0, 10)];
                if ($urandom_range(0, 1) == 1) r[31:25] = f7s[$urandom_range(0, 2)];
                if ($urandom_range(0, 5) == 0) r[11:7] = 5'd0;
            end
        endcase
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        #12;
        check_outputs("reset");
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // addi x1 / lw x2 bundle
        drive(1, 2'b11, 32'h00500093, 32'h0000A103, 32'h100, 0, 1, 0, 0);
        cycle("tp1");
        check_eq("tp1_valid", 64'(issue_valid_o), 64'h3);
        check_eq("tp1_cls0", 64'(issue_class_o[7:0]), 64'h03);
        check_eq("tp1_pc0", 64'(issue_pc_o[31:0]), 64'h100);
        check_eq("tp1_cls1", 64'(issue_class_o[15:8]), 64'h05);
        check_eq("tp1_pc1", 64'(issue_pc_o[63:32]), 64'h104);
        check_eq("tp1_count", 64'(count_o), 64'd2);

        // mul on lane 1 only, M enabled
        drive(1, 2'b10, 32'h00000013, 32'h02B50533, 32'h200, 0, 1, 2, 0);
        cycle("tp_mul");
        check_eq("mul_cls", 64'(issue_class_o[7:0]), 64'h11);
        check_eq("mul_pc", 64'(issue_pc_o[31:0]), 64'h204);
        // mul with M disabled at runtime
        drive(1, 2'b10, 32'h00000013, 32'h02B50533, 32'h300, 0, 0, 1, 0);
        cycle("tp_nomul");
        check_eq("nomul_cls", 64'(issue_class_o[7:0]), 64'hC0);
        check_eq("nomul_pc", 64'(issue_pc_o[31:0]), 64'h304);
        // nop: x0 write suppressed
        drive(1, 2'b01, 32'h00000013, 32'h0, 32'h400, 0, 1, 1, 0);
        cycle("tp_nop");
        check_eq("nop_cls", 64'(issue_class_o[7:0]), 64'h02);
        // faulted bundle
        drive(1, 2'b11, 32'h00500093, 32'h02B50533, 32'h500, 1, 1, 1, 0);
        cycle("tp_fault");
        check_eq("fault_cls0", 64'(issue_class_o[7:0]), 64'h40);
        check_eq("fault_cls1", 64'(issue_class_o[15:8]), 64'h40);

        // Fill to full with no take
        drive(0, 2'b00, 0, 0, 0, 0, 1, 0, 1);
        cycle("flush0");
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'b11, rand_instr(), rand_instr(), 32'h1000 + 32'(8*i), 0, 1, 0, 0);
            cycle("fill");
        end
        check_eq("full_count", 64'(count_o), 64'd8);
        check_eq("full_accept", 64'(fetch_accept_o), 64'd0);
        drive(1, 2'b11, rand_instr(), rand_instr(), 32'h2000, 0, 1, 1, 0);
        cycle("take1");
        check_eq("c7_count", 64'(count_o), 64'd7);
        check_eq("c7_accept", 64'(fetch_accept_o), 64'd0);
        drive(0, 2'b00, 0, 0, 0, 0, 1, 1, 0);
        cycle("take1b");
        drive(1, 2'b11, rand_instr(), rand_instr(), 32'h3000, 0, 1, 2, 0);
        cycle("wrap");
        check_eq("wrap_count", 64'(count_o), 64'd6);
        for (int i = 0; i < 4; i++) begin
            drive(0, 2'b00, 0, 0, 0, 0, 1, 2, 0);
            cycle("drain");
        end

        // Flush during enqueue
        drive(1, 2'b11, rand_instr(), rand_instr(), 32'h4000, 0, 1, 0, 0);
        cycle("pre_flush");
        drive(1, 2'b11, rand_instr(), rand_instr(), 32'h4008, 0, 1, 1, 1);
        cycle("flush");
        check_eq("flush_count", 64'(count_o), 64'd0);
        check_eq("flush_valid", 64'(issue_valid_o), 64'd0);

        // Randomized traffic with a mid-stream reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                #2 rst_ni = 1'b0;
                mq.delete();
                #1 check_outputs("async_rst");
                drive(0, 2'b00, 0, 0, 0, 0, 1, 0, 0);
                @(posedge clk_i);
                #3 rst_ni = 1'b1;
            end
            n = mq.size();
            drive($urandom_range(0, 3) != 0, 2'($urandom), rand_instr(), rand_instr(),
                  {$urandom, 2'b00}, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, (n < LANES) ? n : LANES), $urandom_range(0, 15) == 0);
            cycle("rnd");
        end
        drive(0, 2'b00, 0, 0, 0, 0, 1, 0, 0);
        cycle("final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
